// File: rtl/signal_sender_pkg.sv
// Shared constants for the inter-board line conditioner: timer resolution,
// far-end filter length, default hold window and FSM state encoding.
package signal_sender_pkg;

    localparam int         TICK_NS           = 600;
    localparam logic [7:0] FILTER_TIME       = 8'd200;
    localparam logic [7:0] HOLD_TIME_DEFAULT = 8'd220;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Deadline arithmetic is deliberately 8-bit so it wraps with the shared timer.
    function automatic logic [7:0] calc_deadline(input logic [7:0] now_tick,
                                                 input logic [7:0] hold_ticks);
        calc_deadline = now_tick + hold_ticks;
    endfunction

endpackage

// File: rtl/signal_sender_sync_2ff.sv
// Two-flop synchronizer for asynchronous CPLD inputs; both stages clear to 0
// on the asynchronous active-low reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Metastability-settling chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/signal_sender.sv
// Transmit-side conditioner: every level driven on sout is held for at least
// HOLD_TIME timer ticks; cancelled requests are flagged and transitions counted.
module signal_sender
    import signal_sender_pkg::*;
#(
    parameter logic [7:0] HOLD_TIME = HOLD_TIME_DEFAULT,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       timer_600n,
    input  logic             din,
    output logic             sout,
    output logic             busy,
    output logic             lost,
    output logic [CNT_W-1:0] tx_cnt
);

    logic             din_s;
    logic             expiry_s;
    logic             send_s;
    state_e           state_q, state_d;
    logic             sout_q, sout_d;
    logic [7:0]       deadline_q, deadline_d;
    logic             pending_q, pending_d;
    logic             lost_q, lost_d;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sync_2ff #(.W(1)) u_din_sync (
        .clk (clk),
        .rst (rst),
        .d_i (din),
        .q_o (din_s)
    );

    // Equality compare: the timer dwells on the deadline for many clocks, but
    // leaving HOLD or reloading moves the deadline, so expiry fires only once.
    assign expiry_s = (state_q == HOLD) && (timer_600n == deadline_q);

    // Next-state, output level, deadline and counter decisions.
    always_comb begin
        state_d    = state_q;
        sout_d     = sout_q;
        deadline_d = deadline_q;
        cnt_d      = cnt_q;
        send_s     = 1'b0;

        case (state_q)
            IDLE: begin
                if (din_s != sout_q) begin
                    send_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (expiry_s) begin
                    if (din_s != sout_q) begin
                        send_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (send_s) begin
            sout_d     = din_s;
            deadline_d = calc_deadline(timer_600n, HOLD_TIME);
            state_d    = HOLD;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            sout_d = sout_q;
        end
    end

    // A request cancelled inside the window shows up as pending dropping
    // without an expiry; expiry itself clears pending silently.
    always_comb begin
        pending_d = (state_q == HOLD) && !expiry_s && (din_s != sout_q);
        lost_d    = pending_q && !pending_d && !expiry_s;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sout_q     <= 1'b0;
            deadline_q <= 8'd0;
            pending_q  <= 1'b0;
            lost_q     <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sout_q     <= sout_d;
            deadline_q <= deadline_d;
            pending_q  <= pending_d;
            lost_q     <= lost_d;
            busy_q     <= (state_d == HOLD);
            cnt_q      <= cnt_d;
        end
    end

    assign sout   = sout_q;
    assign busy   = busy_q;
    assign lost   = lost_q;
    assign tx_cnt = cnt_q;

endmodule
